// File: rtl/instruction_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package instruction_fetch_pkg;

  // Canonical RISC-V NOP (addi x0, x0, 0); shown on if_instr while the buffer is empty after reset.
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Default first fetch address after reset.
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

  // IDLE: free to issue a request. WAIT_RSP: one granted request outstanding.
  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC generation, single-outstanding instruction memory
// requests, and a one-entry output buffer handed to decode via valid/ready.
// Redirects flush the buffer and mark any in-flight response as stale.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  input  logic            id_ready
);

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_req;
  logic            r_discard;
  logic            r_if_valid;
  logic [31:0]     r_if_instr;
  logic [XLEN-1:0] r_if_pc;

  logic            w_consume;
  logic            w_req;
  logic [XLEN-1:0] w_redirect_pc;

  // A request goes out only from IDLE into an empty or draining buffer, and
  // never in a redirect cycle, so a grant can never collide with a redirect.
  assign w_consume     = r_if_valid && id_ready;
  assign w_req         = (r_state == IDLE) && !reset && (!r_if_valid || id_ready) && !redirect_valid;
  assign w_redirect_pc = redirect_pc & ALIGN_MASK;

  assign imem_req  = w_req;
  assign imem_addr = r_pc;
  assign if_valid  = r_if_valid;
  assign if_instr  = r_if_instr;
  assign if_pc     = r_if_pc;

  // Fetch FSM, PC update and output buffer; redirect overrides everything but reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_pc_req   <= '0;
      r_discard  <= 1'b0;
      r_if_valid <= 1'b0;
      r_if_instr <= NOP_INSTR;
      r_if_pc    <= '0;
    end else if (redirect_valid) begin
      r_pc       <= w_redirect_pc;
      r_if_valid <= 1'b0;
      if (r_state == WAIT_RSP) begin
        if (imem_rvalid) begin
          // Response arriving with the redirect is already stale: drop it now.
          r_state   <= IDLE;
          r_discard <= 1'b0;
        end else begin
          // Response still in flight: remember to drop it when it lands.
          r_discard <= 1'b1;
        end
      end
    end else begin
      if (w_consume) begin
        r_if_valid <= 1'b0;
      end
      if (r_state == IDLE) begin
        if (w_req && imem_gnt) begin
          r_pc_req <= r_pc;
          r_pc     <= r_pc + PC_STEP;
          r_state  <= WAIT_RSP;
        end
      end else begin
        if (imem_rvalid) begin
          r_state <= IDLE;
          if (r_discard) begin
            r_discard <= 1'b0;
          end else begin
            // Buffer is empty or draining here, so this refill wins over the consume above.
            r_if_valid <= 1'b1;
            r_if_instr <= imem_rdata;
            r_if_pc    <= r_pc_req;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed scenarios with literal
// expectations, then randomized traffic against a program-order model.
module tb_instruction_fetch;

  localparam logic [63:0] RST_PC = 64'h1000;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        id_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int n_xfer   = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.XLEN(64), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready)
  );

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] h;
    if (a == 64'h1000) return 32'h00500093;
    h = a[31:0] ^ a[63:32] ^ 32'h5bd1e995;
    h = h * 32'h9E3779B1;
    return h ^ (h >> 15);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory: one outstanding request, configurable latency, drops pending on reset.
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic        mem_pend = 1'b0;
  logic [63:0] mem_addr = '0;

  assign imem_rvalid = mem_pend && (mem_cnt == 0);
  assign imem_rdata  = imem_rvalid ? mem_word(mem_addr) : 32'hDEADBEEF;

  always @(posedge clk) begin
    if (reset) mem_pend <= 1'b0;
    else if (imem_rvalid) mem_pend <= 1'b0;
    else if (mem_pend) mem_cnt <= mem_cnt - 1;
    if (!reset && imem_req && imem_gnt) begin
      mem_pend <= 1'b1;
      mem_cnt  <= mem_lat - 1;
      mem_addr <= imem_addr;
    end
  end

  // Program-order model: decode must see RESET_PC, +4, +4 ... restarting at
  // each aligned redirect target; fetches go out in the same order, only when
  // nothing is outstanding.
  logic [63:0] m_arch, m_fetch, m_hold_pc;
  logic [31:0] m_hold_instr;
  int          m_out = 0;
  bit          m_hold = 0, m_after_redir = 0, m_after_rst = 0;
  logic        exp_req;

  always @(negedge clk) begin
    if (reset) begin
      chk("req_in_reset", {63'd0, imem_req}, 64'd0);
      m_arch = RST_PC; m_fetch = RST_PC; m_out = 0;
      m_hold = 0; m_after_redir = 0; m_after_rst = 1;
    end else begin
      if (m_after_rst) begin
        chk("rst_if_valid", {63'd0, if_valid}, 64'd0);
        chk("rst_if_instr", {32'd0, if_instr}, {32'd0, NOP});
        chk("rst_if_pc", if_pc, 64'd0);
      end
      if (m_after_redir) chk("flush_after_redirect", {63'd0, if_valid}, 64'd0);
      if (m_hold) begin
        chk("hold_valid", {63'd0, if_valid}, 64'd1);
        chk("hold_instr", {32'd0, if_instr}, {32'd0, m_hold_instr});
        chk("hold_pc", if_pc, m_hold_pc);
      end
      exp_req = (m_out == 0) && !redirect_valid && (!if_valid || id_ready);
      chk("req", {63'd0, imem_req}, {63'd0, exp_req});
      if (imem_req) chk("fetch_addr", imem_addr, m_fetch);
      if (if_valid) chk("instr_of_pc", {32'd0, if_instr}, {32'd0, mem_word(if_pc)});
      if (if_valid && id_ready && !redirect_valid) begin
        chk("xfer_pc", if_pc, m_arch);
        m_arch = m_arch + 64'd4;
        n_xfer++;
      end
      m_hold       = if_valid && !id_ready && !redirect_valid;
      m_hold_instr = if_instr;
      m_hold_pc    = if_pc;
      if (imem_req && imem_gnt) begin
        m_out++;
        m_fetch = m_fetch + 64'd4;
      end
      if (imem_rvalid && m_out > 0) m_out--;
      if (redirect_valid) begin
        m_arch  = {redirect_pc[63:2], 2'b00};
        m_fetch = {redirect_pc[63:2], 2'b00};
      end
      m_after_redir = redirect_valid;
      m_after_rst   = 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (if_valid) seen = 1;
      else cyc();
    end
    if (!seen) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  logic [63:0] tgt;

  initial begin
    reset = 1; imem_gnt = 1; id_ready = 1; redirect_valid = 0; redirect_pc = '0;
    mem_lat = 1;
    repeat (3) cyc();
    reset = 0;
    // T1: first fetch after reset, 2-cycle latency to the buffer
    @(negedge clk);
    chk("t1_req", {63'd0, imem_req}, 64'd1);
    chk("t1_addr", imem_addr, 64'h1000);
    cyc(); @(negedge clk);
    chk("t1_not_yet_valid", {63'd0, if_valid}, 64'd0);
    cyc(); @(negedge clk);
    chk("t1_valid", {63'd0, if_valid}, 64'd1);
    chk("t1_instr", {32'd0, if_instr}, 64'h00500093);
    chk("t1_pc", if_pc, 64'h1000);
    chk("t1_next_addr", imem_addr, 64'h1004);
    // T2: decode stalls for 5 cycles
    cyc(); id_ready = 0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_req_stalled", {63'd0, imem_req}, 64'd0);
      chk("t2_pc_held", if_pc, 64'h1004);
      cyc();
    end
    id_ready = 1; mem_lat = 4;
    @(negedge clk);
    chk("t2_req_on_ready", {63'd0, imem_req}, 64'd1);
    chk("t2_addr", imem_addr, 64'h1008);
    // T3: redirect to unaligned target during WAIT_RSP, stale response 3 cycles later
    cyc(); redirect_valid = 1; redirect_pc = 64'h2002;
    @(negedge clk);
    chk("t3_no_req_redirect", {63'd0, imem_req}, 64'd0);
    cyc(); redirect_valid = 0; mem_lat = 1;
    @(negedge clk);
    chk("t3_wait_stale", {63'd0, imem_req}, 64'd0);
    cyc(); cyc(); @(negedge clk);
    chk("t3_stale_dropped", {63'd0, if_valid}, 64'd0);
    cyc(); @(negedge clk);
    chk("t3_req_target", {63'd0, imem_req}, 64'd1);
    chk("t3_addr_target", imem_addr, 64'h2000);
    cyc(); wait_valid("t3");
    chk("t3_pc", if_pc, 64'h2000);
    chk("t3_instr", {32'd0, if_instr}, {32'd0, mem_word(64'h2000)});
    // T4: redirect coincides with the response
    mem_lat = 2;
    cyc(); cyc(); redirect_valid = 1; redirect_pc = 64'h3000;
    @(negedge clk);
    chk("t4_no_req", {63'd0, imem_req}, 64'd0);
    cyc(); redirect_valid = 0; mem_lat = 1;
    @(negedge clk);
    chk("t4_flushed", {63'd0, if_valid}, 64'd0);
    chk("t4_req", {63'd0, imem_req}, 64'd1);
    chk("t4_addr", imem_addr, 64'h3000);
    cyc(); wait_valid("t4");
    chk("t4_pc", if_pc, 64'h3000);
    // T5: grant withheld, redirect in the second stalled cycle
    cyc(); imem_gnt = 0;
    cyc(); @(negedge clk);
    chk("t5_c1_req", {63'd0, imem_req}, 64'd1);
    chk("t5_c1_addr", imem_addr, 64'h3008);
    cyc(); redirect_valid = 1; redirect_pc = 64'h4000;
    @(negedge clk);
    chk("t5_c2_req", {63'd0, imem_req}, 64'd0);
    cyc(); redirect_valid = 0;
    @(negedge clk);
    chk("t5_c3_addr", imem_addr, 64'h4000);
    cyc(); @(negedge clk);
    chk("t5_c4_req", {63'd0, imem_req}, 64'd1);
    chk("t5_c4_addr", imem_addr, 64'h4000);
    cyc(); imem_gnt = 1;
    wait_valid("t5");
    chk("t5_pc", if_pc, 64'h4000);
    // T6: reset while a fetch is outstanding, then reset with a full buffer
    mem_lat = 3;
    cyc(); reset = 1;
    @(negedge clk);
    cyc(); reset = 0; mem_lat = 1; id_ready = 0;
    @(negedge clk);
    chk("t6_req_restart", {63'd0, imem_req}, 64'd1);
    chk("t6_addr_restart", imem_addr, RST_PC);
    cyc(); wait_valid("t6");
    chk("t6_pc", if_pc, RST_PC);
    chk("t6_instr", {32'd0, if_instr}, 64'h00500093);
    cyc(); reset = 1;
    @(negedge clk);
    cyc(); reset = 0; id_ready = 1;
    @(negedge clk);
    chk("t6_buf_cleared", {63'd0, if_valid}, 64'd0);
    chk("t6_nop", {32'd0, if_instr}, {32'd0, NOP});
    // Randomized traffic checked by the model every cycle
    n_xfer = 0;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      reset          = ($urandom_range(0, 399) == 0);
      imem_gnt       = ($urandom_range(0, 3) != 0);
      id_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = !reset && ($urandom_range(0, 19) == 0);
      tgt            = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
      redirect_pc    = tgt;
      mem_lat        = $urandom_range(1, 3);
    end
    cyc(); reset = 0; redirect_valid = 0;
    @(negedge clk);
    chk("random_progress", {63'd0, n_xfer > 200}, 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Front-end stage that generates the PC, fetches 32-bit RV64 instructions from instruction memory, and presents them to instruction decode over a valid/ready handshake.
- Absorbs branch/jump redirects and discards in-flight fetches made stale by a redirect.
- Supports one outstanding memory request and has a single-entry output buffer.

Parameters:
XLEN, 64, width of PC and instruction-memory address
RESET_PC, 64'h0, PC fetched first after reset

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address (word aligned)
imem_gnt  in  1  request accepted this cycle when imem_req && imem_gnt
imem_rvalid  in  1  response valid; at least 1 cycle after grant; exactly one per grant
imem_rdata  in  32  instruction word
redirect_valid  in  1  PC redirect from branch resolution
redirect_pc  in  XLEN  redirect target
if_valid  out  1  instruction buffer holds a valid instruction
if_instr  out  32  instruction to decode
if_pc  out  XLEN  PC of if_instr
id_ready  in  1  decode accepts; transfer when if_valid && id_ready

Behaviour:
- Reset (reset=1 at edge):
  - pc=RESET_PC, state=IDLE, discard=0.
  - if_valid=0, if_instr=NOP (32'h00000013), if_pc=0.
  - imem_req=0 while reset is high.
  - Reset mid-fetch abandons the request. Memory must drop the pending response on reset.
- State WAIT_RSP: request granted, response outstanding. pc_req holds the granted address.
- State IDLE:
  - imem_req=1, imem_addr=pc when both hold: buffer empty or consumed this cycle (if_valid=0 or id_ready=1), and redirect_valid=0.
  - Otherwise imem_req=0.
  - On grant: pc_req<=pc, pc<=pc+4 (mod 2^XLEN, wraps silently), go to WAIT_RSP.
- imem_addr must stay stable while imem_req=1 and imem_gnt=0, unless a redirect withdraws the request (imem_req=0 that cycle).
- WAIT_RSP, imem_rvalid=1, discard=0:
  - if_instr<=imem_rdata, if_pc<=pc_req, if_valid<=1, go to IDLE.
  - The buffer is guaranteed empty here, because requests are issued only into an empty or draining buffer.
- WAIT_RSP, imem_rvalid=1, discard=1: drop the response, discard<=0, go to IDLE. No output change.
- Handshake: if_valid && id_ready and no redirect sets if_valid<=0 unless refilled that same edge. if_instr and if_pc stay stable while if_valid=1 and id_ready=0.
- Redirect (highest priority, any state):
  - pc<=redirect_pc with bits [1:0] forced to 0. Misalignment is not reported.
  - if_valid<=0 (buffer flushed even if id_ready=1 that cycle; decode treats it as squashed).
  - No request is issued in the redirect cycle.
  - In WAIT_RSP without rvalid: discard<=1, remain in WAIT_RSP.
  - In WAIT_RSP with rvalid the same cycle: response dropped, go to IDLE, discard=0.
  - A grant cannot coincide with a redirect, because imem_req=0.
  - Back-to-back redirects: the last one wins. discard stays set until the single stale response returns.
- Latency: grant at cycle N, response at N+1, if_valid=1 at N+2. Next request issues in N+2 if id_ready=1. Sustained throughput: 1 instruction per 2 cycles with 1-cycle memory.

Decomposition:
- Shared constants file (global include): NOP encoding 32'h00000013, default RESET_PC, state encodings IDLE=1'b0 and WAIT_RSP=1'b1.
- Single flat module. The PC incrementer and buffer are inline; no sub-module is warranted.

Test Plan:
- Reset, RESET_PC=64'h1000, gnt=1, 1-cycle memory returning 32'h00500093 -> imem_addr=64'h1000 first cycle after reset; if_valid=1, if_instr=32'h00500093, if_pc=64'h1000 two cycles later; next request addr 64'h1004.
- id_ready=0 held for 5 cycles with a valid buffer -> imem_req=0 throughout; if_instr/if_pc unchanged; with id_ready=1 the request issues the same cycle.
- Redirect to 64'h2002 during WAIT_RSP; stale response arrives 3 cycles later -> stale word never appears on if_instr; next grant at imem_addr=64'h2000; if_pc=64'h2000.
- Redirect and rvalid in the same cycle -> response dropped; if_valid=0; next request at the redirect target; discard=0.
- imem_gnt=0 for 4 cycles -> imem_req=1 and imem_addr stable; a redirect in cycle 2 drops imem_req for that cycle and then re-requests at the new PC.
- Reset asserted in WAIT_RSP with if_valid=1 -> next cycle if_valid=0, if_instr=32'h00000013, pc=RESET_PC; the fetch restarts after reset deasserts.
